// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl
// ---------------------------------------------------------------------------
// Boot and ownership controller for the pipeline's instruction memory.
// After reset the controller owns the memory write port: it takes a program
// as a valid/ready word stream, zero-fills whatever the program did not
// cover, then hands the memory address port to the fetch stage and releases
// the CPU reset. A reload request in RUN returns ownership to the loader.
//
// Ports
//   clk         sole clock, rising edge
//   reset       asynchronous active-high reset
//   ld_valid    loader word valid
//   ld_data     loader instruction word
//   ld_last     final program word (qualified by the handshake)
//   ld_ready    controller accepts a word this cycle
//   reload      single-cycle request for a new load (honoured in RUN only)
//   fetch_addr  word address from the fetch stage
//   mem_we      instruction-memory write enable
//   mem_addr    instruction-memory address
//   mem_wdata   instruction-memory write data
//   cpu_reset   pipeline reset, high whenever not in RUN
//   load_count  words accepted in the last/current load
//   trunc       sticky: memory filled to DEPTH without ld_last
// ---------------------------------------------------------------------------
module imem_boot_ctrl #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic              reload,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_reset,
    output logic [ADDR_W:0]   load_count,
    output logic              trunc
);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              trunc_q, trunc_d;
    logic              at_end;

    // The pointer never steps past the last word: both exits out of the
    // write phases fire at LAST_ADDR, so the pointer simply holds there.
    assign at_end = (wr_ptr_q == LAST_ADDR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_LOAD;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            trunc_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            trunc_q  <= trunc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        cnt_d     = cnt_q;
        trunc_d   = trunc_q;
        ld_ready  = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = wr_ptr_q;
        mem_wdata = '0;

        unique case (state_q)
            S_LOAD: begin
                // ld_ready is constant here, so a handshake is just ld_valid;
                // the write lands on the same edge as the handshake.
                ld_ready  = 1'b1;
                mem_we    = ld_valid;
                mem_wdata = ld_data;
                if (ld_valid) begin
                    cnt_d = cnt_q + (ADDR_W+1)'(1);
                    if (at_end) begin
                        // Memory full: go straight to RUN, no fill needed.
                        state_d = S_RUN;
                        trunc_d = ~ld_last;
                    end else begin
                        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                        if (ld_last) begin
                            state_d = S_CLEAR;
                        end
                    end
                end
            end

            S_CLEAR: begin
                mem_we = 1'b1;
                if (at_end) begin
                    state_d = S_RUN;
                end else begin
                    wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                end
            end

            S_RUN: begin
                mem_addr = fetch_addr;
                if (reload) begin
                    state_d  = S_LOAD;
                    wr_ptr_d = '0;
                    cnt_d    = '0;
                    trunc_d  = 1'b0;
                end
            end

            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    // Decoded from the state register only, so it cannot glitch on inputs.
    assign cpu_reset  = (state_q != S_RUN);
    assign load_count = cnt_q;
    assign trunc      = trunc_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
module tb_imem_boot_ctrl;
    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          ld_valid = 1'b0;
    logic [DW-1:0] ld_data = '0;
    logic          ld_last = 1'b0;
    logic          ld_ready;
    logic          reload = 1'b0;
    logic [AW-1:0] fetch_addr = '0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          cpu_reset;
    logic [AW:0]   load_count;
    logic          trunc;

    imem_boot_ctrl #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .reload(reload), .fetch_addr(fetch_addr),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset), .load_count(load_count), .trunc(trunc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instruction memory the controller drives.
    logic [DW-1:0] tb_mem  [DEPTH];
    logic [DW-1:0] snap    [DEPTH];
    // Reference: program words followed by zeros.
    logic [DW-1:0] prog    [DEPTH];
    logic [DW-1:0] exp_img [DEPTH];

    always @(posedge clk) if (mem_we === 1'b1) tb_mem[mem_addr] <= mem_wdata;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic build_image(input int n);
        for (int i = 0; i < DEPTH; i++) exp_img[i] = (i < n) ? prog[i] : '0;
    endtask

    function automatic int img_mismatches(input int lo, input int hi);
        int nb = 0;
        for (int i = lo; i <= hi; i++) if (tb_mem[i] !== exp_img[i]) nb++;
        return nb;
    endfunction

    // Streams prog[0..n-1] with random gaps of gmin..gmax cycles between
    // words, waits for RUN, and checks everything the model predicts.
    // rel = edges from first handshake to the RUN-entry edge, minus one.
    task automatic do_load(input int n, input bit last_flag, input int gmin, input int gmax,
                           input bit poke, input string tag, output int rel);
        int  gaps = 0;
        int  first_edge = 0;
        bit  bad_ld = 0;
        bit  bad_clr = 0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                int g = int'($urandom_range(gmax, gmin));
                for (int k = 0; k < g; k++) begin
                    ld_valid = 1'b0;
                    ld_data  = $urandom;
                    ld_last  = 1'($urandom);
                    reload   = poke & 1'($urandom);
                    @(negedge clk);
                    if (mem_we !== 1'b0 || ld_ready !== 1'b1 || cpu_reset !== 1'b1) bad_ld = 1;
                    @(posedge clk); #1;
                    gaps++;
                end
            end
            ld_valid = 1'b1;
            ld_data  = prog[i];
            ld_last  = last_flag && (i == n - 1);
            reload   = poke & 1'($urandom);
            @(negedge clk);
            if (mem_we !== 1'b1 || mem_addr !== AW'(i) || mem_wdata !== prog[i] ||
                ld_ready !== 1'b1 || cpu_reset !== 1'b1) bad_ld = 1;
            @(posedge clk); #1;
            if (i == 0) first_edge = cyc;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        for (int k = 0; k < DEPTH + 8 && cpu_reset !== 1'b0; k++) begin
            reload = poke & 1'($urandom);
            @(negedge clk);
            if (ld_ready !== 1'b0 || mem_we !== 1'b1 || mem_wdata !== '0) bad_clr = 1;
            @(posedge clk); #1;
        end
        reload = 1'b0;
        rel = cyc - first_edge;
        build_image(n);
        chk({tag, "_load_phase"}, bad_ld, 0);
        chk({tag, "_clear_phase"}, bad_clr, 0);
        chk({tag, "_cpu_reset"}, cpu_reset, 0);
        chk({tag, "_run_edge"}, rel, gaps + DEPTH - 1);
        chk({tag, "_load_count"}, load_count, n);
        chk({tag, "_trunc"}, trunc, (n == DEPTH && !last_flag) ? 1 : 0);
        chk({tag, "_mem_image"}, img_mismatches(0, DEPTH - 1), 0);
    endtask

    task automatic do_reload(input string tag);
        reload = 1'b1;
        @(negedge clk);
        chk({tag, "_pre_cpu_reset"}, cpu_reset, 0);
        @(posedge clk); #1;
        reload = 1'b0;
        chk({tag, "_cpu_reset"}, cpu_reset, 1);
        chk({tag, "_ld_ready"}, ld_ready, 1);
        chk({tag, "_load_count"}, load_count, 0);
        chk({tag, "_trunc"}, trunc, 0);
    endtask

    typedef struct {
        logic [AW-1:0] fa;
        logic          vld;
        logic [AW-1:0] e_addr;
        logic          e_we;
        logic          e_rdy;
        logic          e_crst;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int rel1, rel2, rel;
        bit found;
        int nbad;

        // RUN-state routing table
        for (int i = 0; i < 6; i++)
            tbl[i] = '{fa: AW'(i), vld: 1'(i % 2 == 0), e_addr: AW'(i), e_we: 1'b0, e_rdy: 1'b0, e_crst: 1'b0};
        tbl[6] = '{fa: 8'hFF, vld: 1'b1, e_addr: 8'hFF, e_we: 1'b0, e_rdy: 1'b0, e_crst: 1'b0};
        tbl[7] = '{fa: 8'h80, vld: 1'b1, e_addr: 8'h80, e_we: 1'b0, e_rdy: 1'b0, e_crst: 1'b0};

        // Reset state, checked before any clock edge
        #1 reset = 1'b1;
        #1;
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_ld_ready", ld_ready, 1);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_load_count", load_count, 0);
        chk("rst_trunc", trunc, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // 3-word load, no bubbles
        prog[0] = 32'hE3A00001; prog[1] = 32'hE2811002; prog[2] = 32'hE0423003;
        do_load(3, 1'b1, 0, 0, 1'b0, "t1", rel1);
        chk("t1_256_edges", rel1, 255);
        chk("t1_word0", tb_mem[0], 32'hE3A00001);
        chk("t1_word255", tb_mem[255], 0);

        // Fetch routing in RUN
        for (int i = 0; i < 8; i++) begin
            fetch_addr = tbl[i].fa;
            ld_valid   = tbl[i].vld;
            @(negedge clk);
            chk("tbl_mem_addr", mem_addr, tbl[i].e_addr);
            chk("tbl_mem_we", mem_we, tbl[i].e_we);
            chk("tbl_ld_ready", ld_ready, tbl[i].e_rdy);
            chk("tbl_cpu_reset", cpu_reset, tbl[i].e_crst);
            chk("tbl_mem_wdata", mem_wdata, 0);
            @(posedge clk); #1;
        end
        ld_valid = 1'b0;

        // Same words with 2-cycle gaps
        do_reload("rl1");
        do_load(3, 1'b1, 2, 2, 1'b0, "t2", rel2);
        chk("t2_extra_edges", rel2 - rel1, 4);

        // Full memory with and without ld_last
        for (int i = 0; i < DEPTH; i++) prog[i] = $urandom;
        do_reload("rl2");
        do_load(DEPTH, 1'b1, 0, 0, 1'b0, "t3", rel);
        do_reload("rl3");
        do_load(DEPTH, 1'b0, 0, 0, 1'b0, "t3t", rel);

        // 1-word load after reload
        do_reload("rl4");
        prog[0] = 32'hDEADBEEF;
        do_load(1, 1'b1, 0, 0, 1'b0, "t4", rel);

        // Async reset mid-CLEAR at wr_ptr = 100
        do_reload("rl5");
        prog[0] = 32'h11111111; prog[1] = 32'h22222222; prog[2] = 32'h33333333;
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1; ld_data = prog[i]; ld_last = (i == 2);
            @(posedge clk); #1;
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        found = 0;
        for (int k = 0; k < 400 && !found; k++) begin
            if (mem_addr === 8'd100 && cpu_reset === 1'b1) found = 1;
            else begin @(posedge clk); #1; end
        end
        chk("ar_reached_100", found, 1);
        for (int i = 0; i < DEPTH; i++) snap[i] = tb_mem[i];
        #3 reset = 1'b1;
        #1;
        chk("ar_cpu_reset", cpu_reset, 1);
        chk("ar_ld_ready", ld_ready, 1);
        chk("ar_load_count", load_count, 0);
        chk("ar_mem_we", mem_we, 0);
        chk("ar_mem_addr", mem_addr, 0);
        repeat (2) @(posedge clk);
        #1;
        nbad = 0;
        for (int i = 0; i < DEPTH; i++) if (tb_mem[i] !== snap[i]) nbad++;
        chk("ar_mem_untouched", nbad, 0);
        build_image(3);
        chk("ar_low_words", img_mismatches(0, 99), 0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("ar_still_load", cpu_reset, 1);

        // Randomized loads with ignored reload pokes and fetch reads
        for (int r = 0; r < 6; r++) begin
            int  n;
            bit  lf;
            case (r % 3)
                0: begin n = int'($urandom_range(DEPTH - 1, 1)); lf = 1'b1; end
                1: begin n = DEPTH; lf = 1'($urandom); end
                default: begin n = int'($urandom_range(8, 1)); lf = 1'b1; end
            endcase
            for (int i = 0; i < DEPTH; i++) prog[i] = $urandom;
            do_load(n, lf, 0, int'($urandom_range(2, 0)), 1'b1, "rnd", rel);
            for (int k = 0; k < 8; k++) begin
                logic [AW-1:0] a;
                a = AW'($urandom);
                fetch_addr = a;
                ld_valid = 1'($urandom);
                @(negedge clk);
                chk("rnd_fetch_addr", mem_addr, a);
                chk("rnd_fetch_we", mem_we, 0);
                chk("rnd_fetch_data", tb_mem[a], exp_img[a]);
                @(posedge clk); #1;
            end
            ld_valid = 1'b0;
            do_reload("rnd_rl");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
